// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Control sequencer for a multi-cycle RISC-V datapath that shares one ALU and
// one unified instruction/data memory port. Each instruction walks through
// FETCH / DECODE / EXEC / MEM / WB; the block drives the per-state datapath
// enables, waits on the memory ready handshake, and traps on an illegal opcode
// or when memory fails to answer within TIMEOUT cycles.
//
// Optional build macro: MC_PERF_CNT_EN adds the cycle_cnt / instret_cnt
// performance counters (CNT_W bits wide). Without it those ports and their
// logic are absent.

module multicycle_control_fsm #(
    parameter int TIMEOUT = 255,  // max waiting cycles before a timeout trap; 0 disables
    parameter int CNT_W   = 32    // performance counter width
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             en,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             mem_2_reg,
    output logic             trap,
    output logic [1:0]       trap_cause,
`ifdef MC_PERF_CNT_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
`endif
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // All datapath command outputs, grouped so they can be defaulted and
    // gated as one word.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       mem_iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_2_reg;
    } ctl_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] PC_SRC_ALU  = 2'b00;
    localparam logic [1:0] PC_SRC_OUT  = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Wait counter only ever needs to hold TIMEOUT-1 before it trips.
    localparam int              WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    if (TIMEOUT < 0 || CNT_W < 1) begin : g_param_check
        $error("multicycle_control_fsm: TIMEOUT must be >= 0 and CNT_W >= 1");
    end

    state_t            state_q;
    state_t            state_d;
    ctl_t              ctl;
    ctl_t              ctl_out;
    logic [1:0]        cause_d;
    logic              waiting;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_d;

    logic op_r, op_i, op_beq, op_jal, op_load, op_store, op_legal;

    assign op_r     = (opcode == OP_R);
    assign op_i     = (opcode == OP_I);
    assign op_beq   = (opcode == OP_BEQ);
    assign op_jal   = (opcode == OP_JAL);
    assign op_load  = (opcode == OP_LOAD);
    assign op_store = (opcode == OP_STORE);
    assign op_legal = op_r | op_i | op_beq | op_jal | op_load | op_store;

    // Next-state, command outputs and trap cause for the current state.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        ctl     = '0;
        state_d = state_q;
        cause_d = CAUSE_NONE;
        waiting = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (en) begin
                    ctl.mem_read  = 1'b1;
                    ctl.mem_iord  = 1'b0;
                    ctl.alu_src_a = 1'b0;
                    ctl.alu_src_b = SRC_B_FOUR;
                    ctl.alu_op    = ALU_ADD;
                    ctl.pc_src    = PC_SRC_ALU;
                    ctl.ir_write  = mem_ready;
                    ctl.pc_write  = mem_ready;
                    if (mem_ready) state_d = S_DECODE;
                    else           waiting = 1'b1;
                end
            end

            S_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                ctl.alu_src_a = 1'b0;
                ctl.alu_src_b = SRC_B_IMM;
                ctl.alu_op    = ALU_ADD;
                if (op_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end

            S_EXEC: begin
                state_d = S_FETCH;
                if (op_r) begin
                    ctl.alu_src_a = 1'b1;
                    ctl.alu_src_b = SRC_B_RS2;
                    ctl.alu_op    = ALU_RTYPE;
                    state_d       = S_WB;
                end else if (op_i) begin
                    ctl.alu_src_a = 1'b1;
                    ctl.alu_src_b = SRC_B_IMM;
                    ctl.alu_op    = ALU_ADD;
                    state_d       = S_WB;
                end else if (op_load || op_store) begin
                    ctl.alu_src_a = 1'b1;
                    ctl.alu_src_b = SRC_B_IMM;
                    ctl.alu_op    = ALU_ADD;
                    state_d       = S_MEM;
                end else if (op_beq) begin
                    ctl.alu_src_a     = 1'b1;
                    ctl.alu_src_b     = SRC_B_RS2;
                    ctl.alu_op        = ALU_SUB;
                    ctl.pc_write_cond = 1'b1;
                    ctl.pc_src        = PC_SRC_OUT;
                end else if (op_jal) begin
                    ctl.pc_write = 1'b1;
                    ctl.pc_src   = PC_SRC_JUMP;
                end
            end

            S_MEM: begin
                // Request is held until memory answers.
                ctl.mem_iord  = 1'b1;
                ctl.mem_read  = op_load;
                ctl.mem_write = ~op_load;
                if (mem_ready) state_d = op_load ? S_WB : S_FETCH;
                else           waiting = 1'b1;
            end

            S_WB: begin
                ctl.reg_write = 1'b1;
                ctl.mem_2_reg = op_load;
                state_d       = S_FETCH;
            end

            S_TRAP: begin
                state_d = S_TRAP;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Watchdog: the TIMEOUT-th consecutive waiting cycle without mem_ready traps.
        if (TIMEOUT != 0 && waiting && wait_cnt == WAIT_LAST) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TIMEOUT;
        end
    end

    // Any cycle that is not a stalled memory request restarts the wait count.
    assign wait_d = (TIMEOUT != 0 && waiting) ? wait_cnt + 1'b1 : '0;

    // State, sticky trap flag/cause and watchdog counter.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= S_FETCH;
            trap       <= 1'b0;
            trap_cause <= CAUSE_NONE;
            wait_cnt   <= '0;
        end else begin
            // NOTE: registers update with non-blocking assignments so every
            // flop samples the pre-edge values of its neighbours.
            state_q  <= state_d;
            wait_cnt <= wait_d;
            if (state_d == S_TRAP && state_q != S_TRAP) begin
                trap       <= 1'b1;
                trap_cause <= cause_d;
            end
        end
    end

`ifdef MC_PERF_CNT_EN
    logic retire;
    assign retire = (state_d == S_FETCH) &&
                    (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB);

    // Free-running cycle and retired-instruction counters, wrapping naturally.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state_q != S_TRAP) cycle_cnt <= cycle_cnt + 1'b1;
            if (retire)            instret_cnt <= instret_cnt + 1'b1;
        end
    end
`endif

    // NOTE: commands are forced low while reset is asserted, since FETCH with
    // en=1 would otherwise already present a memory read during reset.
    assign ctl_out = arst_n ? ctl : '0;

    assign mem_read      = ctl_out.mem_read;
    assign mem_write     = ctl_out.mem_write;
    assign mem_iord      = ctl_out.mem_iord;
    assign ir_write      = ctl_out.ir_write;
    assign pc_write      = ctl_out.pc_write;
    assign pc_write_cond = ctl_out.pc_write_cond;
    assign pc_src        = ctl_out.pc_src;
    assign alu_src_a     = ctl_out.alu_src_a;
    assign alu_src_b     = ctl_out.alu_src_b;
    assign alu_op        = ctl_out.alu_op;
    assign reg_write     = ctl_out.reg_write;
    assign mem_2_reg     = ctl_out.mem_2_reg;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (TIMEOUT=4). Inputs change on the
// falling edge and outputs are compared 1 ns later; expected per-cycle state and
// command words are hand-computed tables.
// Command word bit order:
// {mem_read, mem_write, mem_iord, ir_write, pc_write, pc_write_cond,
//  pc_src[1:0], alu_src_a, alu_src_b[1:0], alu_op[1:0], reg_write, mem_2_reg}

module tb_multicycle_control_fsm;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 32;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BAD   = 7'b0000000;

    localparam logic [14:0] C_IDLE   = 15'b000_000_00_0_00_00_00;
    localparam logic [14:0] C_F_RDY  = 15'b100_110_00_0_01_00_00;
    localparam logic [14:0] C_F_WAIT = 15'b100_000_00_0_01_00_00;
    localparam logic [14:0] C_DEC    = 15'b000_000_00_0_10_00_00;
    localparam logic [14:0] C_EX_R   = 15'b000_000_00_1_00_10_00;
    localparam logic [14:0] C_EX_IMM = 15'b000_000_00_1_10_00_00;
    localparam logic [14:0] C_EX_BEQ = 15'b000_001_01_1_00_01_00;
    localparam logic [14:0] C_EX_JAL = 15'b000_010_10_0_00_00_00;
    localparam logic [14:0] C_MEM_LD = 15'b101_000_00_0_00_00_00;
    localparam logic [14:0] C_MEM_ST = 15'b011_000_00_0_00_00_00;
    localparam logic [14:0] C_WB_ALU = 15'b000_000_00_0_00_00_10;
    localparam logic [14:0] C_WB_LD  = 15'b000_000_00_0_00_00_11;

    logic             clk = 1'b0;
    logic             arst_n = 1'b1;
    logic             en = 1'b0;
    logic [6:0]       opcode = 7'd0;
    logic             mem_ready = 1'b0;
    logic             mem_read, mem_write, mem_iord, ir_write, pc_write, pc_write_cond;
    logic [1:0]       pc_src, alu_src_b, alu_op, trap_cause;
    logic             alu_src_a, reg_write, mem_2_reg, trap;
    logic [2:0]       state;
`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;
`endif
    logic [14:0]      ctl;

    int errors = 0;
    int checks = 0;

    multicycle_control_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .arst_n(arst_n), .en(en), .opcode(opcode), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_iord(mem_iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .mem_2_reg(mem_2_reg), .trap(trap), .trap_cause(trap_cause),
`ifdef MC_PERF_CNT_EN
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
        .state(state)
    );

    assign ctl = {mem_read, mem_write, mem_iord, ir_write, pc_write, pc_write_cond,
                  pc_src, alu_src_a, alu_src_b, alu_op, reg_write, mem_2_reg};

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pulse reset across one rising edge; returns on a falling edge, released.
    task automatic apply_reset;
        arst_n = 1'b0;
        en = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_reset;
        #2 arst_n = 1'b0;
        en = 1'b1; mem_ready = 1'b1; opcode = OP_R;
        #1;
        checks++;
        if (state !== 3'd0 || ctl !== C_IDLE || trap !== 1'b0 || trap_cause !== 2'b00) begin
            errors++;
            $display("FAIL reset: state=%0d ctl=%b trap=%b cause=%b, want 0 %b 0 00",
                     state, ctl, trap, trap_cause, C_IDLE);
        end
`ifdef MC_PERF_CNT_EN
        checks++;
        if (cycle_cnt !== '0 || instret_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt: cycle=%0d instret=%0d, want 0 0", cycle_cnt, instret_cnt);
        end
`endif
        @(negedge clk);
        arst_n = 1'b1;
        en = 1'b0; mem_ready = 1'b0;
    endtask

    // R-type, zero wait; en dropped after FETCH to show the instruction still completes.
    task automatic test_r_type;
        logic        t_en  [6] = '{1, 0, 0, 0, 0, 0};
        logic [2:0]  t_st  [6] = '{0, 1, 2, 4, 0, 0};
        logic [14:0] t_ctl [6] = '{C_F_RDY, C_DEC, C_EX_R, C_WB_ALU, C_IDLE, C_IDLE};
        apply_reset();
        opcode = OP_R;
        for (int i = 0; i < 6; i++) begin
            en = t_en[i]; mem_ready = t_en[i]; #1;
            checks++;
            if (state !== t_st[i] || ctl !== t_ctl[i]) begin
                errors++;
                $display("FAIL r_type[%0d]: state=%0d ctl=%b, want state=%0d ctl=%b",
                         i, state, ctl, t_st[i], t_ctl[i]);
            end
            tick();
        end
    endtask

    // LOAD with three not-ready cycles in MEM: eight cycles in total.
    task automatic test_load_wait;
        logic        t_en  [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        logic        t_rdy [9] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
        logic [2:0]  t_st  [9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
        logic [14:0] t_ctl [9] = '{C_F_RDY, C_DEC, C_EX_IMM, C_MEM_LD, C_MEM_LD, C_MEM_LD,
                                   C_MEM_LD, C_WB_LD, C_IDLE};
        apply_reset();
        opcode = OP_LOAD;
        for (int i = 0; i < 9; i++) begin
            en = t_en[i]; mem_ready = t_rdy[i]; #1;
            checks++;
            if (state !== t_st[i] || ctl !== t_ctl[i] || trap !== 1'b0) begin
                errors++;
                $display("FAIL load_wait[%0d]: state=%0d ctl=%b trap=%b, want state=%0d ctl=%b trap=0",
                         i, state, ctl, trap, t_st[i], t_ctl[i]);
            end
            tick();
        end
    endtask

    // BEQ then JAL back to back, three cycles each.
    task automatic test_beq_jal;
        logic [6:0]  t_op  [7] = '{OP_BEQ, OP_BEQ, OP_BEQ, OP_JAL, OP_JAL, OP_JAL, OP_JAL};
        logic        t_en  [7] = '{1, 0, 0, 1, 0, 0, 0};
        logic [2:0]  t_st  [7] = '{0, 1, 2, 0, 1, 2, 0};
        logic [14:0] t_ctl [7] = '{C_F_RDY, C_DEC, C_EX_BEQ, C_F_RDY, C_DEC, C_EX_JAL, C_IDLE};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            opcode = t_op[i]; en = t_en[i]; mem_ready = t_en[i]; #1;
            checks++;
            if (state !== t_st[i] || ctl !== t_ctl[i]) begin
                errors++;
                $display("FAIL beq_jal[%0d]: state=%0d ctl=%b, want state=%0d ctl=%b",
                         i, state, ctl, t_st[i], t_ctl[i]);
            end
            tick();
        end
    endtask

    // I-type then STORE, four cycles each.
    task automatic test_i_store;
        logic [6:0]  t_op  [9] = '{OP_I, OP_I, OP_I, OP_I, OP_STORE, OP_STORE, OP_STORE,
                                   OP_STORE, OP_STORE};
        logic        t_en  [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
        logic        t_rdy [9] = '{1, 0, 0, 0, 1, 0, 0, 1, 0};
        logic [2:0]  t_st  [9] = '{0, 1, 2, 4, 0, 1, 2, 3, 0};
        logic [14:0] t_ctl [9] = '{C_F_RDY, C_DEC, C_EX_IMM, C_WB_ALU, C_F_RDY, C_DEC,
                                   C_EX_IMM, C_MEM_ST, C_IDLE};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            opcode = t_op[i]; en = t_en[i]; mem_ready = t_rdy[i]; #1;
            checks++;
            if (state !== t_st[i] || ctl !== t_ctl[i]) begin
                errors++;
                $display("FAIL i_store[%0d]: state=%0d ctl=%b, want state=%0d ctl=%b",
                         i, state, ctl, t_st[i], t_ctl[i]);
            end
            tick();
        end
    endtask

    // Illegal opcode traps after DECODE and only reset leaves TRAP.
    task automatic test_illegal;
        logic [2:0]  t_st    [4] = '{0, 1, 5, 5};
        logic [14:0] t_ctl   [4] = '{C_F_RDY, C_DEC, C_IDLE, C_IDLE};
        logic        t_trap  [4] = '{0, 0, 1, 1};
        logic [1:0]  t_cause [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        apply_reset();
        opcode = OP_BAD;
        for (int i = 0; i < 4; i++) begin
            en = 1'b1; mem_ready = 1'b1; #1;
            checks++;
            if (state !== t_st[i] || ctl !== t_ctl[i] || trap !== t_trap[i] ||
                trap_cause !== t_cause[i]) begin
                errors++;
                $display("FAIL illegal[%0d]: state=%0d ctl=%b trap=%b cause=%b, want %0d %b %b %b",
                         i, state, ctl, trap, trap_cause, t_st[i], t_ctl[i], t_trap[i], t_cause[i]);
            end
            tick();
        end
        arst_n = 1'b0; #1;
        checks++;
        if (state !== 3'd0 || trap !== 1'b0 || trap_cause !== 2'b00 || ctl !== C_IDLE) begin
            errors++;
            $display("FAIL illegal_clear: state=%0d trap=%b cause=%b ctl=%b, want 0 0 00 %b",
                     state, trap, trap_cause, ctl, C_IDLE);
        end
        @(negedge clk);
        arst_n = 1'b1;
        en = 1'b0; mem_ready = 1'b0;
    endtask

    // Four not-ready FETCH cycles trap; ready on the fourth cycle wins instead.
    task automatic test_fetch_timeout;
        logic        t_rdy  [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        logic        t_en   [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        logic [2:0]  t_st   [8] = '{0, 0, 0, 0, 1, 2, 4, 0};
        logic [14:0] t_ctl  [8] = '{C_F_WAIT, C_F_WAIT, C_F_WAIT, C_F_RDY, C_DEC, C_EX_R,
                                    C_WB_ALU, C_IDLE};
        apply_reset();
        opcode = OP_R;
        en = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (i < 4) begin
                if (state !== 3'd0 || ctl !== C_F_WAIT || trap !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_to[%0d]: state=%0d ctl=%b trap=%b, want 0 %b 0",
                             i, state, ctl, trap, C_F_WAIT);
                end
            end else if (state !== 3'd5 || ctl !== C_IDLE || trap !== 1'b1 || trap_cause !== 2'b10) begin
                errors++;
                $display("FAIL fetch_to_trap: state=%0d ctl=%b trap=%b cause=%b, want 5 %b 1 10",
                         state, ctl, trap, trap_cause, C_IDLE);
            end
            tick();
        end
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            en = t_en[i]; mem_ready = t_rdy[i]; #1;
            checks++;
            if (state !== t_st[i] || ctl !== t_ctl[i] || trap !== 1'b0) begin
                errors++;
                $display("FAIL fetch_late[%0d]: state=%0d ctl=%b trap=%b, want state=%0d ctl=%b trap=0",
                         i, state, ctl, trap, t_st[i], t_ctl[i]);
            end
            tick();
        end
    endtask

    // LOAD whose MEM phase never gets ready traps with the timeout cause.
    task automatic test_mem_timeout;
        logic        t_en  [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
        logic        t_rdy [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
        logic [2:0]  t_st  [8] = '{0, 1, 2, 3, 3, 3, 3, 5};
        logic [14:0] t_ctl [8] = '{C_F_RDY, C_DEC, C_EX_IMM, C_MEM_LD, C_MEM_LD, C_MEM_LD,
                                   C_MEM_LD, C_IDLE};
        apply_reset();
        opcode = OP_LOAD;
        for (int i = 0; i < 8; i++) begin
            en = t_en[i]; mem_ready = t_rdy[i]; #1;
            checks++;
            if (state !== t_st[i] || ctl !== t_ctl[i]) begin
                errors++;
                $display("FAIL mem_to[%0d]: state=%0d ctl=%b, want state=%0d ctl=%b",
                         i, state, ctl, t_st[i], t_ctl[i]);
            end
            tick();
        end
        checks++;
        if (trap !== 1'b1 || trap_cause !== 2'b10) begin
            errors++;
            $display("FAIL mem_to_cause: trap=%b cause=%b, want 1 10", trap, trap_cause);
        end
    endtask

    // Reset asserted during EXEC aborts at once, then fetching restarts.
    task automatic test_reset_midflight;
        apply_reset();
        opcode = OP_R; en = 1'b1; mem_ready = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (state !== 3'd2) begin
            errors++;
            $display("FAIL mid_pre: state=%0d, want 2", state);
        end
        arst_n = 1'b0; #1;
        checks++;
        if (state !== 3'd0 || ctl !== C_IDLE) begin
            errors++;
            $display("FAIL mid_abort: state=%0d ctl=%b, want 0 %b", state, ctl, C_IDLE);
        end
        @(negedge clk);
        arst_n = 1'b1; #1;
        checks++;
        if (state !== 3'd0 || ctl !== C_F_RDY) begin
            errors++;
            $display("FAIL mid_restart: state=%0d ctl=%b, want 0 %b", state, ctl, C_F_RDY);
        end
        en = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
    endtask

`ifdef MC_PERF_CNT_EN
    // Four zero-wait R instructions: 16 cycles, 4 retired; then idle with en=0.
    task automatic test_perf_cnt;
        apply_reset();
        #1;
        checks++;
        if (cycle_cnt !== '0 || instret_cnt !== '0) begin
            errors++;
            $display("FAIL perf_reset: cycle=%0d instret=%0d, want 0 0", cycle_cnt, instret_cnt);
        end
        opcode = OP_R; en = 1'b1; mem_ready = 1'b1;
        repeat (16) tick();
        en = 1'b0; #1;
        checks++;
        if (cycle_cnt !== 32'd16 || instret_cnt !== 32'd4 || state !== 3'd0 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL perf_4r: cycle=%0d instret=%0d state=%0d rd=%b, want 16 4 0 0",
                     cycle_cnt, instret_cnt, state, mem_read);
        end
        tick();
        tick();
        #1;
        checks++;
        if (cycle_cnt !== 32'd18 || instret_cnt !== 32'd4 || state !== 3'd0 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL perf_idle: cycle=%0d instret=%0d state=%0d rd=%b, want 18 4 0 0",
                     cycle_cnt, instret_cnt, state, mem_read);
        end
    endtask
`endif

    // Scenario sequence and final summary.
    initial begin
        test_reset();
        test_r_type();
        test_load_wait();
        test_beq_jal();
        test_i_store();
        test_illegal();
        test_fetch_timeout();
        test_mem_timeout();
        test_reset_midflight();
`ifdef MC_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle sequencer for the RISC-V datapath: one shared ALU, one unified instruction/data memory port.
- Steps each instruction through FETCH / DECODE / EXEC / MEM / WB.
- Drives the per-state datapath enables and handles the memory ready handshake.
- Traps on an illegal opcode or a memory timeout. Sits beside the register file, ALU and ALU control, which decodes alu_op.

Parameters:
- TIMEOUT, 255: maximum cycles waiting for mem_ready in FETCH or MEM before trapping. 0 disables the watchdog.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock.
- arst_n  in  1  reset, asynchronous active-low.
- en  in  1  run enable, sampled only in FETCH.
- opcode  in  7  IR[6:0]. Stable from DECODE until the instruction completes.
- mem_ready  in  1  memory accepts/returns this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_iord  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  IR load.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- pc_src  out  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump target.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs1.
- alu_src_b  out  2  ALU B select: 00 rs2, 01 const 4, 10 imm.
- alu_op  out  2  00 add, 01 sub, 10 R-type.
- reg_write  out  1  register file write.
- mem_2_reg  out  1  write-back source: 1 = MDR.
- trap  out  1  sticky; set on entry to TRAP.
- trap_cause  out  2  01 illegal opcode, 10 memory timeout; 00 otherwise.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

Behaviour:
- Supported opcodes: R 0110011, I 0010011, BEQ 1100011, JAL 1101111, LOAD 0000011, STORE 0100011.
- Registered: state, trap, trap_cause, wait counter. All other outputs are combinational from state, opcode, mem_ready and en.
- Reset: state=FETCH, trap=0, trap_cause=00, wait counter=0. While arst_n=0, every command output is 0.
- Any output not listed for a state is 0.
- FETCH, en=0: all outputs 0; stay in FETCH.
- FETCH, en=1: mem_read=1, mem_iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write equal mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut).
  - Supported opcode -> EXEC; otherwise -> TRAP with cause 01.
- EXEC, by opcode:
  - R: a=1, b=00, op=10 -> WB.
  - I: a=1, b=10, op=00 -> WB.
  - LOAD/STORE: a=1, b=10, op=00 -> MEM.
  - BEQ: a=1, b=00, op=01, pc_write_cond=1, pc_src=01 -> FETCH.
  - JAL: pc_write=1, pc_src=10 -> FETCH. No link write.
- MEM: mem_iord=1.
  - LOAD: mem_read=1; mem_ready -> WB.
  - STORE: mem_write=1; mem_ready -> FETCH.
  - Without mem_ready: stay, holding the request.
- WB: reg_write=1, mem_2_reg=1 if LOAD else 0 -> FETCH.
- TRAP: all command outputs 0; exit only by reset.
- Zero-wait cycle counts: R/I 4, LOAD 5, STORE 4, BEQ 3, JAL 3. Each wait cycle adds 1.
- Watchdog:
  - Counter clears on entering FETCH(en=1) or MEM and on any mem_ready=1.
  - Increments each waiting cycle.
  - On reaching TIMEOUT with mem_ready still 0 -> TRAP, cause 10.
  - mem_ready=1 on the TIMEOUT-th cycle wins: no trap.
- en is ignored outside FETCH; an instruction in flight always completes.
- Reset mid-instruction aborts immediately and restarts in FETCH.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- When defined: adds outputs cycle_cnt[CNT_W-1:0] and instret_cnt[CNT_W-1:0], both reset to 0.
  - cycle_cnt increments every cycle when not in TRAP.
  - instret_cnt increments on each transition into FETCH from EXEC, MEM or WB.
  - Both wrap modulo 2^CNT_W.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then R opcode, mem_ready=1 -> states 0,1,2,4,0; reg_write=1 only in WB with mem_2_reg=0; alu_op=10 in EXEC.
- LOAD with mem_ready low 3 cycles in MEM -> MEM held 4 cycles with mem_read=1, mem_iord=1; then WB with mem_2_reg=1; 8 cycles total.
- BEQ then JAL -> EXEC shows pc_write_cond=1, pc_src=01, alu_op=01, then pc_write=1, pc_src=10; each instruction takes 3 cycles.
- opcode 0000000 -> TRAP after DECODE, trap=1, trap_cause=01, all enables 0; arst_n pulse -> state=0, trap=0.
- TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP with cause 10 after 4 wait cycles; repeat with mem_ready=1 on cycle 4 -> DECODE, no trap.
- MC_PERF_CNT_EN defined, four R instructions, zero wait -> instret_cnt=4, cycle_cnt=16; en=0 in FETCH holds state with mem_read=0.
